// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared opcode/state encodings and default sizes for the datapath sequencer.
package datapath_seq_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SHL = 4'd4,
        OP_SHR = 4'd5,
        OP_NOT = 4'd6,
        OP_MUL = 4'd7
    } opcode_t;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T_Y  = 3'd1,
        S_T_Z  = 3'd2,
        S_T_WB = 3'd3,
        S_DONE = 3'd4
    } state_t;
endpackage

// File: rtl/datapath_seq_alu.sv
// alu_param: combinational ALU producing a double-width result; upper half is zero except for MUL.
module alu_param
    import datapath_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [3:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] z
);
    localparam int SH_W = $clog2(DATA_W);
    logic [SH_W-1:0]   w_sh;
    logic [DATA_W-1:0] w_lo;
    assign w_sh = b[SH_W-1:0];
    always_comb begin
        w_lo = op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_SHL ? a << w_sh :
               op == OP_SHR ? a >> w_sh : ~b;
        z = op == OP_MUL ? {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b} : {{DATA_W{1'b0}}, w_lo};
    end
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: register file with a shared bus, Y/Z temporaries and HI/LO, sequenced
// through T_Y (read A), T_Z (read B, compute), T_WB (write back) and DONE.
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rc,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] bus_data,
    output logic [DATA_W-1:0] hi_data,
    output logic [DATA_W-1:0] lo_data
);
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_y, r_hi, r_lo;
    logic [2*DATA_W-1:0] r_z;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_ra, r_rb, r_rc;
    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   w_bus;
    logic [2*DATA_W-1:0] w_alu;
    logic                w_idle, w_legal, w_mul;

    assign w_idle  = r_state == S_IDLE;
    assign w_legal = !r_op[3];
    assign w_mul   = r_op == OP_MUL;

    // Single bus mux; write-back in T_WB follows both reads, so rc aliasing ra/rb is safe.
    assign w_bus = r_state == S_T_Y  ? r_regs[r_ra] :
                   r_state == S_T_Z  ? r_regs[r_rb] :
                   r_state == S_T_WB ? r_z[DATA_W-1:0] : '0;

    assign w_next = r_state == S_IDLE ? (start ? S_T_Y : S_IDLE) :
                    r_state == S_T_Y  ? S_T_Z :
                    r_state == S_T_Z  ? S_T_WB :
                    r_state == S_T_WB ? S_DONE : S_IDLE;

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .op (r_op),
        .a  (r_y),
        .b  (w_bus),
        .z  (w_alu)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rc    <= '0;
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
            if (w_idle && start) begin
                r_op <= opcode;
                r_ra <= ra;
                r_rb <= rb;
                r_rc <= rc;
            end
            if (w_idle && ld_en) r_regs[ld_addr] <= ld_data;
            if (r_state == S_T_Y) r_y <= w_bus;
            if (r_state == S_T_Z) r_z <= w_alu;
            if (r_state == S_T_WB && w_legal && !w_mul) r_regs[r_rc] <= w_bus;
            if (r_state == S_T_WB && w_mul) begin
                r_hi <= r_z[2*DATA_W-1:DATA_W];
                r_lo <= r_z[DATA_W-1:0];
            end
        end
    end

    assign rd_data  = r_regs[rd_addr];
    assign busy     = !w_idle;
    assign done     = r_state == S_DONE;
    assign err      = done && r_op[3];
    assign bus_data = w_bus;
    assign hi_data  = r_hi;
    assign lo_data  = r_lo;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed checks of the datapath sequencer (32x16 and 16x8 instances).
module tb_datapath_seq;
    logic        clk = 1'b0;
    logic        clr, start, ld_en;
    logic [3:0]  opcode, ra, rb, rc, ld_addr, rd_addr;
    logic [31:0] ld_data, rd_data, bus_data, hi_data, lo_data;
    logic        busy, done, err;

    logic        s_start, s_ld_en;
    logic [3:0]  s_opcode;
    logic [2:0]  s_ra, s_rb, s_rc, s_ld_addr, s_rd_addr;
    logic [15:0] s_ld_data, s_rd_data, s_bus, s_hi, s_lo;
    logic        s_busy, s_done, s_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_seq u_dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .bus_data(bus_data), .hi_data(hi_data), .lo_data(lo_data)
    );

    datapath_seq #(.DATA_W(16), .NUM_REGS(8)) u_small (
        .clk(clk), .clr(clr), .start(s_start), .opcode(s_opcode),
        .ra(s_ra), .rb(s_rb), .rc(s_rc),
        .ld_en(s_ld_en), .ld_addr(s_ld_addr), .ld_data(s_ld_data),
        .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .busy(s_busy), .done(s_done), .err(s_err),
        .bus_data(s_bus), .hi_data(s_hi), .lo_data(s_lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Start edge, then T_Y, T_Z, T_WB; done must appear only after the 4th edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c, input logic exp_err);
        start = 1'b1; opcode = op; ra = a; rb = b; rc = c;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        tick();
        tick();
        check({tag, "_done_early"}, done, 1'b0);
        tick();
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_bus_done"}, bus_data, 32'h0);
        tick();
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; ld_en = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
        ld_addr = '0; ld_data = '0; rd_addr = '0;
        s_start = 1'b0; s_ld_en = 1'b0; s_opcode = '0; s_ra = '0; s_rb = '0; s_rc = '0;
        s_ld_addr = '0; s_ld_data = '0; s_rd_addr = '0;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_bus", bus_data, 32'h0);
        check_reg("rst_r0", 4'd0, 32'h0);
        clr = 1'b1;
        tick();

        load(4'd1, 32'd5);
        load(4'd2, 32'd7);
        check_reg("ld_r1", 4'd1, 32'd5);
        start = 1'b1; opcode = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3;
        tick();
        start = 1'b0;
        check("add_bus_ty", bus_data, 32'd5);
        tick();
        check("add_bus_tz", bus_data, 32'd7);
        tick();
        check("add_bus_twb", bus_data, 32'd12);
        check("add_done_twb", done, 1'b0);
        tick();
        check("add_done", done, 1'b1);
        check("add_err", err, 1'b0);
        tick();
        check("add_idle", busy, 1'b0);
        check_reg("add_r3", 4'd3, 32'd12);

        load(4'd1, 32'hFFFF_FFFF);
        load(4'd2, 32'h2);
        run_op("mul", 4'd7, 4'd1, 4'd2, 4'd3, 1'b0);
        check("mul_hi", hi_data, 32'h1);
        check("mul_lo", lo_data, 32'hFFFF_FFFE);
        check_reg("mul_r3_kept", 4'd3, 32'd12);
        check_reg("mul_r1_kept", 4'd1, 32'hFFFF_FFFF);

        load(4'd4, 32'h0);
        load(4'd1, 32'h1);
        run_op("sub", 4'd1, 4'd4, 4'd1, 4'd5, 1'b0);
        check_reg("sub_r5", 4'd5, 32'hFFFF_FFFF);
        load(4'd6, 32'h8000_0000);
        load(4'd7, 32'd31);
        run_op("shr", 4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
        check_reg("shr_r8", 4'd8, 32'h1);
        run_op("shl", 4'd4, 4'd8, 4'd7, 4'd9, 1'b0);
        check_reg("shl_r9", 4'd9, 32'h8000_0000);
        run_op("and", 4'd2, 4'd5, 4'd6, 4'd10, 1'b0);
        check_reg("and_r10", 4'd10, 32'h8000_0000);
        run_op("or", 4'd3, 4'd1, 4'd2, 4'd11, 1'b0);
        check_reg("or_r11", 4'd11, 32'h3);
        run_op("not", 4'd6, 4'd0, 4'd2, 4'd12, 1'b0);
        check_reg("not_r12", 4'd12, 32'hFFFF_FFFD);
        run_op("alias", 4'd0, 4'd1, 4'd1, 4'd1, 1'b0);
        check_reg("alias_r1", 4'd1, 32'h2);
        check("alias_hi_kept", hi_data, 32'h1);

        start = 1'b1; opcode = 4'd9; ra = 4'd1; rb = 4'd2; rc = 4'd3;
        tick();
        opcode = 4'd0; rc = 4'd4;
        tick();
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 32'hDEAD;
        tick();
        ld_en = 1'b0;
        tick();
        start = 1'b0;
        check("ill_done", done, 1'b1);
        check("ill_err", err, 1'b1);
        tick();
        check("ill_idle", busy, 1'b0);
        check_reg("ill_r3", 4'd3, 32'd12);
        check_reg("ill_r4", 4'd4, 32'h0);
        check("ill_hi", hi_data, 32'h1);
        check("ill_lo", lo_data, 32'hFFFF_FFFE);

        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'd100;
        run_op("ldst", 4'd0, 4'd1, 4'd2, 4'd13, 1'b0);
        ld_en = 1'b0;
        check_reg("ldst_r13", 4'd13, 32'd102);

        start = 1'b1; opcode = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd14;
        tick();
        start = 1'b0;
        tick();
        check("clr_in_tz", bus_data, 32'd2);
        clr = 1'b0;
        #1;
        check("clr_busy", busy, 1'b0);
        check("clr_bus", bus_data, 32'h0);
        check("clr_hi", hi_data, 32'h0);
        check("clr_lo", lo_data, 32'h0);
        check_reg("clr_r1", 4'd1, 32'h0);
        tick();
        tick();
        check("clr_no_done", done, 1'b0);
        clr = 1'b1;
        tick();
        tick();
        check("clr_stay_idle", busy, 1'b0);
        check_reg("clr_r14", 4'd14, 32'h0);

        s_ld_en = 1'b1; s_ld_addr = 3'd1; s_ld_data = 16'hFFFF;
        tick();
        s_ld_addr = 3'd2; s_ld_data = 16'h1;
        tick();
        s_ld_en = 1'b0;
        s_ld_addr = 3'd3; s_ld_data = 16'h5555;
        s_ld_en = 1'b1;
        tick();
        s_ld_en = 1'b0;
        s_start = 1'b1; s_opcode = 4'd0; s_ra = 3'd1; s_rb = 3'd2; s_rc = 3'd3;
        tick();
        s_start = 1'b0;
        tick();
        tick();
        tick();
        check("w16_done", s_done, 1'b1);
        tick();
        s_rd_addr = 3'd3;
        #1;
        check("w16_add_wrap", s_rd_data, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the width of the bus, registers and ALU operands.
REQ-002 The block SHALL take parameter NUM_REGS, default 16, as the general register count; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL derive localparam ADDR_W = clog2(NUM_REGS).
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port clr, input, width 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, width 1: operation request, sampled in IDLE only.
REQ-007 The block SHALL have port opcode, input, width 4: ALU operation, captured with start.
REQ-008 The block SHALL have ports ra, rb, rc, input, width ADDR_W each: operand A, operand B and destination indices, captured with start.
REQ-009 The block SHALL have ports ld_en, input, width 1; ld_addr, input, width ADDR_W; ld_data, input, width DATA_W: host register write.
REQ-010 The block SHALL have port rd_addr, input, width ADDR_W, and port rd_data, output, width DATA_W: combinational register read.
REQ-011 The block SHALL have ports busy and done, output, width 1 each: busy = operation in flight; done = one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, width 1: high with done when opcode was illegal.
REQ-013 The block SHALL have ports bus_data, hi_data and lo_data, output, width DATA_W each: current bus value and the HI and LO registers.

Function
REQ-014 The FSM SHALL have states IDLE, T_Y, T_Z, T_WB and DONE, with sequence IDLE->T_Y->T_Z->T_WB->DONE->IDLE.
REQ-015 In IDLE, start=1 SHALL capture opcode, ra, rb and rc and move the FSM to T_Y on that edge; start in any other state SHALL be ignored.
REQ-016 In T_Y, the bus SHALL carry R[ra], and Y SHALL load the bus value.
REQ-017 In T_Z, the bus SHALL carry R[rb], and Z (2*DATA_W) SHALL load alu(Y, bus).
REQ-018 In T_WB, the bus SHALL carry Z_LO, and R[rc] SHALL load the bus value; for MUL, HI SHALL load Z_HI and LO SHALL load Z_LO instead, leaving R[rc] unchanged.
REQ-019 In IDLE and DONE, bus_data SHALL be 0.
REQ-020 busy SHALL be 1 in T_Y, T_Z, T_WB and DONE; done SHALL be 1 in DONE only, giving done exactly 4 cycles after the start edge.
REQ-021 Opcodes SHALL be: 0 ADD, 1 SUB (Y-bus), 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 NOT (~bus), 7 MUL (unsigned, 2*DATA_W result).
REQ-022 For SHL and SHR, the shift amount SHALL be bus[clog2(DATA_W)-1:0].
REQ-023 ADD and SUB SHALL wrap modulo 2^DATA_W; for every non-MUL op, Z_HI SHALL be 0.
REQ-024 Opcodes 8-15 SHALL be illegal: no register, HI or LO write in T_WB; err=1 in DONE.
REQ-025 ld_en SHALL write ld_data to R[ld_addr] only in IDLE and SHALL be ignored otherwise.
REQ-026 When ld_en and start occur in the same IDLE cycle, both SHALL be accepted; the operation SHALL observe the loaded value.
REQ-027 When rc equals ra or rb, the write-back SHALL occur after both reads, so operands are the pre-operation values.

Reset
REQ-028 clr=0 SHALL immediately clear all registers, Y, Z, HI, LO and the captured fields, and force the FSM to IDLE.
REQ-029 During reset, busy, done, err and bus_data SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL abort it with no write-back and no done pulse.

Structure
REQ-031 A shared package SHALL hold the opcode enum, the FSM state enum and the DATA_W and NUM_REGS defaults.
REQ-032 The ALU SHALL be one combinational sub-module, alu_param, parametrised by DATA_W.
REQ-033 The bus SHALL be a single source-select mux driven by the FSM state.

Verification
REQ-034 Scenario: load R1=5, R2=7; start ADD ra=1 rb=2 rc=3 -> done 4 cycles later, R3=12, err=0.
REQ-035 Scenario: R1=0xFFFFFFFF, R2=0x2; MUL -> HI=0x1, LO=0xFFFFFFFE, R-file unchanged.
REQ-036 Scenario: R4=0; SUB ra=4 rb=1 with R1=1 -> rc=0xFFFFFFFF; SHR of 0x80000000 by 31 -> 0x1.
REQ-037 Scenario: opcode 9 -> done with err=1 and no register changes; start pulses while busy are ignored.
REQ-038 Scenario: ld_en+start in the same cycle loading ra -> result uses the new value; clr pulled low in T_Z -> all zero, no done.
REQ-039 Scenario: DATA_W=16, NUM_REGS=8 instance, ADD 0xFFFF+0x1 -> 0x0000.
